// File: rtl/ts_pkg.sv
// Shared definitions for the TS slot arbiter: FSM encoding and frame constants.
package ts_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_MARK,
        S_PASS,
        S_GRANT,
        S_ERR
    } state_t;

    localparam logic [7:0] FRAME_HEAD = 8'hFF;
    localparam logic [7:0] FRAME_FREE = 8'hEE;
    localparam int         FRAME_LEN  = 10;
    localparam int         PAY_LEN    = 7;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible channel after last_grant, wrapping.
module rr_pick #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  elig,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = IDX_W'((int'(last_grant) + i) % N_CH);
            if (elig[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts_slot_arbiter.sv
// Watches TS frames for free-slot markers and grants the payload slot to one
// channel FIFO, round-robin among channels holding a full payload.
module ts_slot_arbiter #(
    parameter int WORD_SIZE = 8,
    parameter int N_CH      = 4,
    parameter int FRAME_LEN = ts_pkg::FRAME_LEN,
    parameter int PAY_LEN   = ts_pkg::PAY_LEN,
    parameter int LVL_W     = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      SYNC,
    input  logic [WORD_SIZE-1:0]      TS_IN,
    input  logic [N_CH*LVL_W-1:0]     LVL,
    output logic [N_CH-1:0]           RDREQ,
    output logic [$clog2(N_CH)-1:0]   SEL,
    output logic                      INSERT,
    output logic                      ERR,
    output logic                      BUSY
);

    import ts_pkg::*;

    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(FRAME_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  rdreq_q, rdreq_d;
    logic             insert_q, insert_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_CH-1:0]  elig;
    logic [IDX_W-1:0] pick;
    logic             pick_vld;
    logic             head_ok;
    logic             last_word;
    logic             sync_accept;

    assign head_ok     = (TS_IN == WORD_SIZE'(FRAME_HEAD));
    assign last_word   = (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign sync_accept = (state_q == S_IDLE) && SYNC && head_ok;

    always_comb begin
        elig = '0;
        for (int k = 0; k < N_CH; k++) begin
            elig[k] = (LVL[k*LVL_W +: LVL_W] >= LVL_W'(PAY_LEN));
        end
    end

    rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .elig       (elig),
        .last_grant (last_q),
        .grant      (pick),
        .valid      (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdreq_d  = rdreq_q;
        insert_d = insert_q;
        sel_d    = sel_q;
        last_d   = last_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (SYNC && head_ok) begin
                    state_d = S_HDR;
                    cnt_d   = CNT_W'(1);
                end else if (SYNC) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_HDR: begin
                state_d = S_MARK;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_MARK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (TS_IN == WORD_SIZE'(FRAME_FREE) && pick_vld) begin
                    state_d  = S_GRANT;
                    rdreq_d  = N_CH'(1) << pick;
                    insert_d = 1'b1;
                    sel_d    = pick;
                    last_d   = pick;
                end else begin
                    state_d = S_PASS;
                end
            end
            S_PASS, S_GRANT: begin
                if (last_word) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    rdreq_d  = '0;
                    insert_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rdreq_q  <= '0;
            insert_q <= 1'b0;
            err_q    <= 1'b0;
            sel_q    <= '0;
            last_q   <= IDX_W'(N_CH - 1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdreq_q  <= rdreq_d;
            insert_q <= insert_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
        end
    end

    assign RDREQ  = rdreq_q;
    assign INSERT = insert_q;
    assign ERR    = err_q;
    assign SEL    = sel_q;
    // BUSY already covers the header word itself, so it spans all FRAME_LEN words.
    assign BUSY   = ((state_q != S_IDLE) && (state_q != S_ERR)) || (sync_accept && !RESET);

endmodule
